// File: rtl/control_rx_network_bridge_mp_pkg.sv
// Shared control API definitions for the receive-side network-to-control bridge:
// stream/field geometry, FSM encoding, tuser packing and port-slot layout.
package control_rx_network_bridge_mp_pkg;

  localparam int unsigned IP_PORT_WIDTH        = 16;
  localparam int unsigned IP_ADDR_WIDTH        = 32;
  localparam int unsigned DATA_WIDTH           = 64;
  localparam int unsigned KEEP_WIDTH           = DATA_WIDTH / 8;
  localparam int unsigned TID_WIDTH            = 8;
  localparam int unsigned TDEST_WIDTH          = 8;
  localparam int unsigned SENDER_TID_OFFSET    = 0;
  localparam int unsigned TID_OFFSET           = 8;
  localparam int unsigned LAN_HDR_TID_OFFSET   = 0;
  localparam int unsigned LAN_HDR_TDEST_OFFSET = 8;
  localparam int unsigned IN_TUSER_WIDTH       = IP_PORT_WIDTH + IP_ADDR_WIDTH;
  localparam int unsigned OUT_TUSER_WIDTH      = 2 * IP_PORT_WIDTH + IP_ADDR_WIDTH;
  localparam int unsigned MAX_CTRL_PORTS       = 4;

  typedef enum logic [1:0] {StIdle, StLanPayload, StForward, StDrop} bridge_state_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]      tdata;
    logic [KEEP_WIDTH-1:0]      tkeep;
    logic [TID_WIDTH-1:0]       tid;
    logic [TDEST_WIDTH-1:0]     tdest;
    logic [OUT_TUSER_WIDTH-1:0] tuser;
    logic                       tlast;
  } ctrl_beat_t;

  // Output tuser = {src port, destination port, src IP}.
  function automatic logic [OUT_TUSER_WIDTH-1:0] pack_tuser(
    input logic [IN_TUSER_WIDTH-1:0] in_tuser,
    input logic [IP_PORT_WIDTH-1:0]  dest
  );
    return {in_tuser[IN_TUSER_WIDTH-1 -: IP_PORT_WIDTH], dest, in_tuser[IP_ADDR_WIDTH-1:0]};
  endfunction

  // Port slot i occupies bits [i*IP_PORT_WIDTH +: IP_PORT_WIDTH].
  function automatic logic [IP_PORT_WIDTH-1:0] port_slot(
    input logic [MAX_CTRL_PORTS*IP_PORT_WIDTH-1:0] ports,
    input int unsigned                             idx
  );
    return ports[idx*IP_PORT_WIDTH +: IP_PORT_WIDTH];
  endfunction

endpackage

// File: rtl/control_rx_bridge_fifo.sv
// Synchronous show-ahead FIFO; output reads as zero while empty.
module control_rx_bridge_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign do_pop  = pop && !empty;
  // A push into a full FIFO is legal only when a pop frees the slot in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign dout  = empty ? '0 : mem[rd_ptr_q];

endmodule

// File: rtl/control_rx_network_bridge_mp.sv
// Steers received packets addressed to a control port into the control stream, wraps other
// traffic via its LAN header or drops it, and counts dropped packets.
module control_rx_network_bridge_mp
  import control_rx_network_bridge_mp_pkg::*;
#(
  parameter int unsigned NUM_CTRL_PORTS = 2,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned LAN_HDR_EN     = 1,
  parameter int unsigned DROP_CNT_WIDTH = 16
) (
  input  logic                                    i_clk,
  input  logic                                    i_ap_rst_n,
  input  logic [NUM_CTRL_PORTS*IP_PORT_WIDTH-1:0] i_CTRL_KIP_port_numbers,
  input  logic                                    from_receptionist_tvalid,
  output logic                                    from_receptionist_tready,
  input  logic [DATA_WIDTH-1:0]                   from_receptionist_tdata,
  input  logic [KEEP_WIDTH-1:0]                   from_receptionist_tkeep,
  input  logic [IP_PORT_WIDTH-1:0]                from_receptionist_tdest,
  input  logic [IN_TUSER_WIDTH-1:0]               from_receptionist_tuser,
  input  logic                                    from_receptionist_tlast,
  output logic                                    to_ctrl_tvalid,
  input  logic                                    to_ctrl_tready,
  output logic [DATA_WIDTH-1:0]                   to_ctrl_tdata,
  output logic [KEEP_WIDTH-1:0]                   to_ctrl_tkeep,
  output logic [TID_WIDTH-1:0]                    to_ctrl_tid,
  output logic [TDEST_WIDTH-1:0]                  to_ctrl_tdest,
  output logic [OUT_TUSER_WIDTH-1:0]              to_ctrl_tuser,
  output logic                                    to_ctrl_tlast,
  output logic [DROP_CNT_WIDTH-1:0]               o_drop_count
);

  bridge_state_e                         state_q, state_d;
  logic [MAX_CTRL_PORTS*IP_PORT_WIDTH-1:0] ports_ext;
  logic                                  match, accept, push, drop_inc, latch_en;
  logic                                  fifo_full, fifo_empty;
  ctrl_beat_t                            wr_beat, rd_beat;
  logic [TID_WIDTH-1:0]                  meta_tid_q, lat_tid;
  logic [TDEST_WIDTH-1:0]                meta_tdest_q, lat_tdest;
  logic [OUT_TUSER_WIDTH-1:0]            meta_tuser_q, lat_tuser;
  logic [DROP_CNT_WIDTH-1:0]             drop_count_q;

  always_comb begin
    ports_ext = '0;
    ports_ext[NUM_CTRL_PORTS*IP_PORT_WIDTH-1:0] = i_CTRL_KIP_port_numbers;
    match = 1'b0;
    for (int unsigned i = 0; i < NUM_CTRL_PORTS; i++) begin
      if (port_slot(ports_ext, i) != '0 && port_slot(ports_ext, i) == from_receptionist_tdest) begin
        match = 1'b1;
      end
    end
  end

  assign accept = from_receptionist_tvalid && from_receptionist_tready;

  always_ff @(posedge i_clk or negedge i_ap_rst_n) begin
    if (!i_ap_rst_n) state_q <= StIdle;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (accept) begin
      unique case (state_q)
        StIdle: begin
          if (from_receptionist_tlast) state_d = StIdle;
          else if (match)              state_d = StForward;
          else if (LAN_HDR_EN != 0)    state_d = StLanPayload;
          else                         state_d = StDrop;
        end
        StLanPayload: state_d = from_receptionist_tlast ? StIdle : StForward;
        StForward:    if (from_receptionist_tlast) state_d = StIdle;
        StDrop:       if (from_receptionist_tlast) state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    from_receptionist_tready = !fifo_full;
    push          = 1'b0;
    drop_inc      = 1'b0;
    latch_en      = 1'b0;
    wr_beat.tdata = from_receptionist_tdata;
    wr_beat.tkeep = from_receptionist_tkeep;
    wr_beat.tlast = from_receptionist_tlast;
    wr_beat.tid   = meta_tid_q;
    wr_beat.tdest = meta_tdest_q;
    wr_beat.tuser = meta_tuser_q;
    lat_tid       = meta_tid_q;
    lat_tdest     = meta_tdest_q;
    lat_tuser     = meta_tuser_q;
    unique case (state_q)
      StIdle: begin
        if (match) begin
          push          = from_receptionist_tvalid && !fifo_full;
          wr_beat.tid   = from_receptionist_tdata[SENDER_TID_OFFSET +: TID_WIDTH];
          wr_beat.tdest = from_receptionist_tdata[TID_OFFSET +: TDEST_WIDTH];
          wr_beat.tuser = pack_tuser(from_receptionist_tuser, from_receptionist_tdest);
          latch_en      = push;
          lat_tid       = wr_beat.tid;
          lat_tdest     = wr_beat.tdest;
          lat_tuser     = wr_beat.tuser;
        end else begin
          from_receptionist_tready = 1'b1;
          drop_inc = from_receptionist_tvalid && from_receptionist_tlast;
          if (LAN_HDR_EN != 0) begin
            latch_en  = from_receptionist_tvalid;
            lat_tid   = from_receptionist_tdata[LAN_HDR_TID_OFFSET +: TID_WIDTH];
            lat_tdest = from_receptionist_tdata[LAN_HDR_TDEST_OFFSET +: TDEST_WIDTH];
          end
        end
      end
      StLanPayload: begin
        push          = from_receptionist_tvalid && !fifo_full;
        wr_beat.tuser = pack_tuser(from_receptionist_tuser, from_receptionist_tdest);
        latch_en      = push;
        lat_tuser     = wr_beat.tuser;
      end
      StForward: push = from_receptionist_tvalid && !fifo_full;
      StDrop: begin
        from_receptionist_tready = 1'b1;
        drop_inc = from_receptionist_tvalid && from_receptionist_tlast;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_ap_rst_n) begin
    if (!i_ap_rst_n) begin
      meta_tid_q   <= '0;
      meta_tdest_q <= '0;
      meta_tuser_q <= '0;
      drop_count_q <= '0;
    end else begin
      if (latch_en) begin
        meta_tid_q   <= lat_tid;
        meta_tdest_q <= lat_tdest;
        meta_tuser_q <= lat_tuser;
      end
      if (drop_inc && drop_count_q != '1) drop_count_q <= drop_count_q + DROP_CNT_WIDTH'(1);
    end
  end

  control_rx_bridge_fifo #(
    .WIDTH ($bits(ctrl_beat_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .rst_n (i_ap_rst_n),
    .push  (push),
    .din   (wr_beat),
    .pop   (to_ctrl_tready),
    .dout  (rd_beat),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign to_ctrl_tvalid = !fifo_empty;
  assign to_ctrl_tdata  = rd_beat.tdata;
  assign to_ctrl_tkeep  = rd_beat.tkeep;
  assign to_ctrl_tid    = rd_beat.tid;
  assign to_ctrl_tdest  = rd_beat.tdest;
  assign to_ctrl_tuser  = rd_beat.tuser;
  assign to_ctrl_tlast  = rd_beat.tlast;
  assign o_drop_count   = drop_count_q;

endmodule

// File: tb/tb_control_rx_network_bridge_mp.sv
// Directed bench: instance a uses the LAN header path, instance b drops non-matching traffic
// with a 2-bit drop counter so saturation is reachable by traffic alone.
module tb_control_rx_network_bridge_mp;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        s_valid = 1'b0, s_last = 1'b0, target = 1'b0;
  logic [63:0] s_data = '0;
  logic [7:0]  s_keep = '0;
  logic [15:0] s_dest = '0;
  logic [47:0] s_user = '0;
  logic [31:0] ports = 32'h0000_1F90;

  logic        rdy_a, ov_a, ordy_a, olast_a;
  logic [63:0] odata_a, ouser_a;
  logic [7:0]  okeep_a, otid_a, otdest_a;
  logic [15:0] drop_a;
  logic        rdy_b, ov_b, ordy_b, olast_b;
  logic [63:0] odata_b, ouser_b;
  logic [7:0]  okeep_b, otid_b, otdest_b;
  logic [1:0]  drop_b;

  int n_checks = 0;
  int n_fail = 0;

  control_rx_network_bridge_mp #(
    .NUM_CTRL_PORTS(2), .FIFO_DEPTH(8), .LAN_HDR_EN(1), .DROP_CNT_WIDTH(16)
  ) dut_a (
    .i_clk(clk), .i_ap_rst_n(rst_n), .i_CTRL_KIP_port_numbers(ports),
    .from_receptionist_tvalid(s_valid && !target), .from_receptionist_tready(rdy_a),
    .from_receptionist_tdata(s_data), .from_receptionist_tkeep(s_keep),
    .from_receptionist_tdest(s_dest), .from_receptionist_tuser(s_user),
    .from_receptionist_tlast(s_last),
    .to_ctrl_tvalid(ov_a), .to_ctrl_tready(ordy_a), .to_ctrl_tdata(odata_a),
    .to_ctrl_tkeep(okeep_a), .to_ctrl_tid(otid_a), .to_ctrl_tdest(otdest_a),
    .to_ctrl_tuser(ouser_a), .to_ctrl_tlast(olast_a), .o_drop_count(drop_a)
  );

  control_rx_network_bridge_mp #(
    .NUM_CTRL_PORTS(2), .FIFO_DEPTH(8), .LAN_HDR_EN(0), .DROP_CNT_WIDTH(2)
  ) dut_b (
    .i_clk(clk), .i_ap_rst_n(rst_n), .i_CTRL_KIP_port_numbers(ports),
    .from_receptionist_tvalid(s_valid && target), .from_receptionist_tready(rdy_b),
    .from_receptionist_tdata(s_data), .from_receptionist_tkeep(s_keep),
    .from_receptionist_tdest(s_dest), .from_receptionist_tuser(s_user),
    .from_receptionist_tlast(s_last),
    .to_ctrl_tvalid(ov_b), .to_ctrl_tready(ordy_b), .to_ctrl_tdata(odata_b),
    .to_ctrl_tkeep(okeep_b), .to_ctrl_tid(otid_b), .to_ctrl_tdest(otdest_b),
    .to_ctrl_tuser(ouser_b), .to_ctrl_tlast(olast_b), .o_drop_count(drop_b)
  );

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [63:0] d, input logic [15:0] dest, input logic [47:0] user,
                      input logic last, input logic tgt);
    int guard;
    target = tgt; s_data = d; s_keep = 8'hFF; s_dest = dest; s_user = user; s_last = last;
    s_valid = 1'b1;
    guard = 0;
    #1;
    while (!(tgt ? rdy_b : rdy_a) && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    if (guard >= 50) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: tready stuck at 0, required 1");
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic pop_a();
    ordy_a = 1'b1;
    @(posedge clk); #1;
    ordy_a = 1'b0;
  endtask

  function automatic logic [63:0] bp_data(input int i);
    return {16'hBEEF, 16'h0000, 16'(i), 8'(8'h40 + i), 8'(i)};
  endfunction

  task automatic test_reset();
    n_checks++; if (ov_a !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid_a: got %b req 0", ov_a); end
    n_checks++; if (ov_b !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid_b: got %b req 0", ov_b); end
    n_checks++; if (odata_a !== 64'h0) begin n_fail++; $display("FAIL reset_tdata: got %h req 0", odata_a); end
    n_checks++; if (ouser_a !== 64'h0) begin n_fail++; $display("FAIL reset_tuser: got %h req 0", ouser_a); end
    n_checks++; if (drop_a !== 16'h0) begin n_fail++; $display("FAIL reset_drop_a: got %h req 0", drop_a); end
    n_checks++; if (drop_b !== 2'h0) begin n_fail++; $display("FAIL reset_drop_b: got %h req 0", drop_b); end
  endtask

  task automatic test_match_single();
    send(64'h1122_3344_5566_0A07, 16'h1F90, {16'h1234, 32'hC0A8_0001}, 1'b1, 1'b0);
    n_checks++; if (ov_a !== 1'b1) begin n_fail++; $display("FAIL match_latency: tvalid %b req 1", ov_a); end
    n_checks++; if (otid_a !== 8'h07) begin n_fail++; $display("FAIL match_tid: got %h req 07", otid_a); end
    n_checks++; if (otdest_a !== 8'h0A) begin n_fail++; $display("FAIL match_tdest: got %h req 0a", otdest_a); end
    n_checks++; if (olast_a !== 1'b1) begin n_fail++; $display("FAIL match_tlast: got %b req 1", olast_a); end
    n_checks++;
    if (ouser_a !== 64'h1234_1F90_C0A8_0001) begin
      n_fail++; $display("FAIL match_tuser: got %h req 12341f90c0a80001", ouser_a);
    end
    n_checks++; if (okeep_a !== 8'hFF) begin n_fail++; $display("FAIL match_tkeep: got %h req ff", okeep_a); end
    @(posedge clk); #1;
    n_checks++;
    if (ov_a !== 1'b1 || odata_a !== 64'h1122_3344_5566_0A07) begin
      n_fail++; $display("FAIL match_stable: tvalid %b tdata %h req 1/1122334455660a07", ov_a, odata_a);
    end
    pop_a();
    n_checks++; if (ov_a !== 1'b0) begin n_fail++; $display("FAIL match_popped: tvalid %b req 0", ov_a); end
  endtask

  task automatic test_lan_header();
    logic [63:0] pd [3];
    pd[0] = 64'hAAAA_0000_0000_0001; pd[1] = 64'hBBBB_0000_0000_0002; pd[2] = 64'hCCCC_0000_0000_0003;
    send(64'h0000_0000_0000_0503, 16'h1234, {16'h0050, 32'h0A00_0002}, 1'b0, 1'b0);
    n_checks++; if (ov_a !== 1'b0) begin n_fail++; $display("FAIL lan_hdr_written: tvalid %b req 0", ov_a); end
    for (int i = 0; i < 3; i++) send(pd[i], 16'h1234, {16'h0050, 32'h0A00_0002}, i == 2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (ov_a !== 1'b1 || odata_a !== pd[i]) begin
        n_fail++; $display("FAIL lan_beat%0d_data: tvalid %b tdata %h req 1/%h", i, ov_a, odata_a, pd[i]);
      end
      n_checks++;
      if (otid_a !== 8'h03 || otdest_a !== 8'h05) begin
        n_fail++; $display("FAIL lan_beat%0d_ids: tid %h tdest %h req 03/05", i, otid_a, otdest_a);
      end
      n_checks++;
      if (olast_a !== (i == 2)) begin n_fail++; $display("FAIL lan_beat%0d_tlast: got %b", i, olast_a); end
      n_checks++;
      if (ouser_a !== 64'h0050_1234_0A00_0002) begin
        n_fail++; $display("FAIL lan_beat%0d_tuser: got %h req 005012340a000002", i, ouser_a);
      end
      pop_a();
    end
    n_checks++; if (ov_a !== 1'b0) begin n_fail++; $display("FAIL lan_extra_beat: tvalid %b req 0", ov_a); end
    n_checks++; if (drop_a !== 16'h0) begin n_fail++; $display("FAIL lan_drop_count: got %h req 0", drop_a); end
  endtask

  task automatic test_drop();
    for (int i = 0; i < 4; i++) send(64'h100 + 64'(i), 16'h1234, 48'h0, i == 3, 1'b1);
    n_checks++; if (ov_b !== 1'b0) begin n_fail++; $display("FAIL drop_output: tvalid %b req 0", ov_b); end
    n_checks++; if (drop_b !== 2'd1) begin n_fail++; $display("FAIL drop_count_1: got %0d req 1", drop_b); end
    for (int i = 0; i < 2; i++) send(64'h200 + 64'(i), 16'h0000, 48'h0, i == 1, 1'b1);
    n_checks++; if (ov_b !== 1'b0) begin n_fail++; $display("FAIL drop_slot0_output: tvalid %b req 0", ov_b); end
    n_checks++; if (drop_b !== 2'd2) begin n_fail++; $display("FAIL drop_count_2: got %0d req 2", drop_b); end
  endtask

  task automatic test_saturate();
    // Counter width is 2, so it now sits at all-ones minus one.
    for (int i = 0; i < 3; i++) begin
      send(64'h300, 16'h0777, 48'h0, 1'b1, 1'b1);
      n_checks++; if (drop_b !== 2'd3) begin n_fail++; $display("FAIL sat_drop%0d: got %0d req 3", i, drop_b); end
    end
  endtask

  task automatic test_back_to_back();
    int acc = 0;
    int rx = 0;
    logic in_ok;
    ordy_a = 1'b0;
    target = 1'b0;
    for (int cyc = 0; cyc < 20 && acc < 10; cyc++) begin
      s_data = bp_data(acc); s_dest = 16'h1F90; s_user = 48'h0; s_last = 1'b1; s_valid = 1'b1;
      #1; in_ok = rdy_a;
      @(posedge clk); #1;
      if (in_ok) acc++;
    end
    n_checks++; if (acc != 8) begin n_fail++; $display("FAIL bp_accepted: got %0d req 8", acc); end
    #1;
    n_checks++; if (rdy_a !== 1'b0) begin n_fail++; $display("FAIL bp_tready: got %b req 0", rdy_a); end
    ordy_a = 1'b1;
    for (int cyc = 0; cyc < 40 && rx < 10; cyc++) begin
      if (acc < 10) begin s_data = bp_data(acc); s_valid = 1'b1; end
      else s_valid = 1'b0;
      #1;
      in_ok = s_valid && rdy_a;
      n_checks++;
      if (ov_a !== 1'b1) begin
        n_fail++; $display("FAIL bp_bubble: tvalid %b at beat %0d req 1", ov_a, rx);
      end else begin
        if (odata_a !== bp_data(rx) || otid_a !== 8'(rx) || otdest_a !== 8'(8'h40 + rx)) begin
          n_fail++; $display("FAIL bp_order%0d: tdata %h tid %h req %h", rx, odata_a, otid_a, bp_data(rx));
        end
        rx++;
      end
      @(posedge clk); #1;
      if (in_ok) acc++;
    end
    s_valid = 1'b0;
    ordy_a = 1'b0;
    n_checks++; if (rx != 10) begin n_fail++; $display("FAIL bp_delivered: got %0d req 10", rx); end
    #1;
    n_checks++; if (ov_a !== 1'b0) begin n_fail++; $display("FAIL bp_drained: tvalid %b req 0", ov_a); end
  endtask

  task automatic test_reset_mid_packet();
    ordy_a = 1'b0;
    send(64'h0000_0000_0000_0201, 16'h1F90, 48'h1, 1'b0, 1'b0);
    send(64'h0000_0000_0000_0BEE, 16'h1F90, 48'h1, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (ov_a !== 1'b0) begin n_fail++; $display("FAIL rst_mid_tvalid: got %b req 0", ov_a); end
    n_checks++; if (odata_a !== 64'h0) begin n_fail++; $display("FAIL rst_mid_tdata: got %h req 0", odata_a); end
    n_checks++; if (otid_a !== 8'h0) begin n_fail++; $display("FAIL rst_mid_tid: got %h req 0", otid_a); end
    n_checks++; if (drop_b !== 2'd0) begin n_fail++; $display("FAIL rst_mid_drop: got %0d req 0", drop_b); end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    send(64'h0000_0000_0000_2211, 16'h1F90, {16'h0001, 32'h0000_0002}, 1'b1, 1'b0);
    n_checks++; if (ov_a !== 1'b1) begin n_fail++; $display("FAIL rst_fresh_tvalid: got %b req 1", ov_a); end
    n_checks++;
    if (otid_a !== 8'h11 || otdest_a !== 8'h22 || olast_a !== 1'b1) begin
      n_fail++; $display("FAIL rst_fresh_fields: tid %h tdest %h tlast %b req 11/22/1", otid_a, otdest_a, olast_a);
    end
    n_checks++;
    if (ouser_a !== 64'h0001_1F90_0000_0002) begin
      n_fail++; $display("FAIL rst_fresh_tuser: got %h req 00011f9000000002", ouser_a);
    end
    pop_a();
    n_checks++; if (ov_a !== 1'b0) begin n_fail++; $display("FAIL rst_fresh_extra: tvalid %b req 0", ov_a); end
  endtask

  initial begin
    ordy_a = 1'b0;
    ordy_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_match_single();
    test_lan_header();
    test_drop();
    test_saturate();
    test_back_to_back();
    test_reset_mid_packet();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/control_rx_network_bridge_mp.md
CONTROL_RX_NETWORK_BRIDGE_MP -- requirements
Module: control_rx_network_bridge_mp

Interface
REQ-001 SHALL take parameter NUM_CTRL_PORTS, default 2, number of control KIP ports matched (1..4).
REQ-002 SHALL take parameter FIFO_DEPTH, default 8, output buffer depth in beats (power of 2, 2..16).
REQ-003 SHALL take parameter LAN_HDR_EN, default 1; 1 = non-matching packets carry a LAN header beat, 0 = non-matching packets are dropped.
REQ-004 SHALL take parameter DROP_CNT_WIDTH, default 16, width of drop counter.
REQ-005 SHALL take all stream and field widths and offsets from the shared control API header parameters.
REQ-006 Ports SHALL be:
- i_clk  in  1  sole clock
- i_ap_rst_n  in  1  asynchronous active-low reset
- i_CTRL_KIP_port_numbers  in  NUM_CTRL_PORTS*IP_PORT_WIDTH  control ports; value 0 = slot disabled
- from_receptionist_tvalid/tready/tdata/tkeep/tdest/tuser/tlast  in/out/in/in/in/in/in  AXIS receive stream; tdest = destination port, tuser = {src port, src IP}
- to_ctrl_tvalid/tready/tdata/tkeep/tid/tdest/tuser/tlast  out/in/out/out/out/out/out/out  AXIS stream to control
- o_drop_count  out  DROP_CNT_WIDTH  packets discarded since reset

Function
REQ-007 Match SHALL be asserted when from_receptionist_tdest equals any non-zero port slot.
REQ-008 FSM SHALL have states IDLE, LAN_PAYLOAD, FORWARD, DROP.
REQ-009 from_receptionist_tready SHALL be 1 in DROP, 1 in IDLE when the beat will not be written to the FIFO, and otherwise !fifo_full.
REQ-010 IDLE with match SHALL write the beat: tid = SENDER_TID field, tdest = TID field, tuser = {src port, tdest, src IP}; tlast=1 -> IDLE, else -> FORWARD, latching the metadata.
REQ-011 IDLE without match and LAN_HDR_EN=1 SHALL consume the header beat without writing it, latching LAN_HDR TID/TDEST; tlast=1 -> increment drop count and stay IDLE, else -> LAN_PAYLOAD.
REQ-012 LAN_PAYLOAD SHALL write the beat with the latched tid/tdest and tuser built from that beat; tlast=1 -> IDLE, else -> FORWARD.
REQ-013 FORWARD SHALL write each beat with the latched tid/tdest/tuser and pass tdata/tkeep/tlast unchanged; the tlast beat -> IDLE.
REQ-014 IDLE without match and LAN_HDR_EN=0 SHALL discard the beat; tlast=1 -> increment drop count and stay IDLE, else -> DROP.
REQ-015 DROP SHALL discard beats and, on the tlast beat, increment the drop count and go to IDLE.
REQ-016 o_drop_count SHALL saturate at all-ones.
REQ-017 Output latency SHALL be 1 cycle: a beat accepted at edge N is presented with to_ctrl_tvalid=1 after edge N.
REQ-018 The output SHALL be show-ahead, with to_ctrl_tvalid = FIFO non-empty, and SHALL pop on tvalid&&tready.
REQ-019 Output fields SHALL be stable while tvalid=1 and tready=0.
REQ-020 Simultaneous push and pop SHALL be permitted when the FIFO is full; occupancy is then unchanged, and tready is still driven by the registered full flag.
REQ-021 No beat SHALL be lost or reordered, and zero bubbles SHALL be inserted when to_ctrl_tready=1.

Reset
REQ-022 Asserting i_ap_rst_n=0 at any time, including mid-packet, SHALL immediately force: state IDLE, FIFO empty, to_ctrl_tvalid=0, all to_ctrl data fields 0, latched metadata 0, o_drop_count 0.
REQ-023 After deassertion, the first beat seen SHALL be treated as a packet start.

Structure
REQ-024 State encoding and the tuser pack layout SHALL live in the shared control API package.
REQ-025 The port-number vector layout SHALL also live in the shared control API package.
REQ-026 The FIFO SHALL be sub-module control_rx_bridge_fifo: synchronous, show-ahead, parametrised width and depth, with full and empty flags.

Verification
REQ-027 With port slots {0x1F90, 0}, a 1-beat packet with tdest=0x1F90 and tlast=1 SHALL produce one output beat 1 cycle later, tid/tdest extracted and tlast=1.
REQ-028 With LAN_HDR_EN=1, header (TID=3, TDEST=5) followed by 3 payload beats SHALL produce 3 output beats, all tid=3 and tdest=5, tlast only on the third.
REQ-029 With LAN_HDR_EN=0, a 4-beat packet with tdest=0x1234 SHALL produce no output and o_drop_count=1; a 2-beat packet to disabled slot value 0 SHALL also drop.
REQ-030 Holding to_ctrl_tready=0 with 10 beats offered and FIFO_DEPTH=8 SHALL accept exactly 8 beats, then deassert tready; releasing tready SHALL deliver all 10 in order.
REQ-031 Asserting reset on beat 2 of a 5-beat FORWARD packet SHALL drive tvalid=0 and count 0; a fresh 1-beat matching packet SHALL then pass normally.
REQ-032 Forcing the count to all-ones minus 1 and dropping 3 packets SHALL leave o_drop_count saturated at all-ones.
